// File: rtl/decoder_rr_arbiter.sv
// Round-robin sequencer sharing one n-to-2^n decoder; grant held until release, then one GAP cycle.
// Optional hold watchdog compiled in with `define DEC_ARB_TIMEOUT_EN.
module decoder_rr_arbiter #(
    parameter int n        = 3,
    parameter int HOLD_MAX = 16
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [(1<<n)-1:0]   req_i,
    input  logic [(1<<n)-1:0]   done_i,
    output logic                dec_en_o,
    output logic [n-1:0]        dec_sel_o,
    output logic [(1<<n)-1:0]   grant_o,
    output logic                busy_o,
    output logic                timeout_o
);

    localparam int N = 1 << n;

    if (HOLD_MAX < 1) begin : g_hold_chk
        $error("HOLD_MAX must be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [n-1:0]   ptr_q, ptr_d;
    logic [n-1:0]   sel_q, sel_d;
    logic [N-1:0]   grant_q, grant_d;
    logic           en_q, en_d;
    logic           busy_q, busy_d;
    logic           timeout_q, timeout_d;

    logic           win_found;
    logic [n-1:0]   win_idx;
    logic [n-1:0]   scan_idx;
    logic           release_c;

`ifdef DEC_ARB_TIMEOUT_EN
    localparam int HW = $clog2(HOLD_MAX + 1);
    logic [HW-1:0]  hold_q, hold_d;
`endif

    // Scan starts just after the last owner, so the previous winner is considered last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int i = 1; i <= N; i++) begin
            scan_idx = ptr_q + n'(i);
            if (!win_found && req_i[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    assign release_c = done_i[sel_q] | ~req_i[sel_q];

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        grant_d   = grant_q;
        en_d      = en_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
`ifdef DEC_ARB_TIMEOUT_EN
        hold_d    = hold_q;
`endif
        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (win_found) begin
                    state_d = S_GRANT;
                    ptr_d   = win_idx;
                    sel_d   = win_idx;
                    grant_d = N'(1) << win_idx;
                    en_d    = 1'b1;
                    busy_d  = 1'b1;
`ifdef DEC_ARB_TIMEOUT_EN
                    hold_d  = '0;
`endif
                end
            end
            S_GRANT: begin
                if (release_c) begin
                    state_d = S_GAP;
                    grant_d = '0;
                    en_d    = 1'b0;
                end
`ifdef DEC_ARB_TIMEOUT_EN
                else if (hold_q == HW'(HOLD_MAX - 1)) begin
                    state_d   = S_GAP;
                    grant_d   = '0;
                    en_d      = 1'b0;
                    timeout_d = 1'b1;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
`endif
            end
            S_GAP: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
                en_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            ptr_q     <= n'(N - 1);
            sel_q     <= '0;
            grant_q   <= '0;
            en_q      <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            grant_q   <= grant_d;
            en_q      <= en_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

`ifdef DEC_ARB_TIMEOUT_EN
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) hold_q <= '0;
        else         hold_q <= hold_d;
    end
`endif

    assign dec_en_o  = en_q;
    assign dec_sel_o = sel_q;
    assign grant_o   = grant_q;
    assign busy_o    = busy_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Directed bench for decoder_rr_arbiter (n=3, HOLD_MAX=4): vector table plus multi-cycle sequences.
module tb_decoder_rr_arbiter;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic [7:0] req_i;
    logic [7:0] done_i;
    logic       dec_en_o;
    logic [2:0] dec_sel_o;
    logic [7:0] grant_o;
    logic       busy_o;
    logic       timeout_o;

    int checks = 0;
    int errors = 0;

    decoder_rr_arbiter #(.n(3), .HOLD_MAX(4)) dut (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .req_i     (req_i),
        .done_i    (done_i),
        .dec_en_o  (dec_en_o),
        .dec_sel_o (dec_sel_o),
        .grant_o   (grant_o),
        .busy_o    (busy_o),
        .timeout_o (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [7:0] req;
        logic [7:0] done;
        logic       en;
        logic [2:0] sel;
        logic [7:0] grant;
        logic       busy;
        string      name;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic en, input logic [2:0] sel,
                           input logic [7:0] grant, input logic busy, input logic tmo);
        chk({name, ".en"},    32'(dec_en_o),  32'(en));
        chk({name, ".sel"},   32'(dec_sel_o), 32'(sel));
        chk({name, ".grant"}, 32'(grant_o),   32'(grant));
        chk({name, ".busy"},  32'(busy_o),    32'(busy));
        chk({name, ".tmo"},   32'(timeout_o), 32'(tmo));
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        req_i   = '0;
        done_i  = '0;
        tick();
        tick();
        reset_i = 1'b0;
    endtask

    vec_t vecs[18];
    int   en_cnt;
    logic hold_ok;

    initial begin
        vecs[0]  = '{8'h01, 8'h00, 1, 3'd0, 8'h01, 1, "t1_grant0"};
        vecs[1]  = '{8'h01, 8'h01, 0, 3'd0, 8'h00, 1, "t1_gap"};
        vecs[2]  = '{8'h00, 8'h00, 0, 3'd0, 8'h00, 0, "t1_idle"};
        vecs[3]  = '{8'h20, 8'h00, 1, 3'd5, 8'h20, 1, "t3_grant5"};
        vecs[4]  = '{8'h24, 8'h00, 1, 3'd5, 8'h20, 1, "t3_hold5"};
        vecs[5]  = '{8'h24, 8'h20, 0, 3'd5, 8'h00, 1, "t3_gap"};
        vecs[6]  = '{8'h24, 8'h00, 0, 3'd5, 8'h00, 0, "t3_idle"};
        vecs[7]  = '{8'h24, 8'h00, 1, 3'd2, 8'h04, 1, "t3_wrap2"};
        vecs[8]  = '{8'h20, 8'h00, 0, 3'd2, 8'h00, 1, "t3_drop_gap"};
        vecs[9]  = '{8'h00, 8'h00, 0, 3'd2, 8'h00, 0, "t3_idle2"};
        vecs[10] = '{8'h08, 8'h00, 1, 3'd3, 8'h08, 1, "t4_grant3"};
        vecs[11] = '{8'h08, 8'h40, 1, 3'd3, 8'h08, 1, "t4_done_other"};
        vecs[12] = '{8'h00, 8'h00, 0, 3'd3, 8'h00, 1, "t4_drop_gap"};
        vecs[13] = '{8'h00, 8'h00, 0, 3'd3, 8'h00, 0, "t4_idle"};
        vecs[14] = '{8'h08, 8'h00, 1, 3'd3, 8'h08, 1, "sim_grant3"};
        vecs[15] = '{8'h00, 8'h08, 0, 3'd3, 8'h00, 1, "sim_gap"};
        vecs[16] = '{8'h00, 8'h00, 0, 3'd3, 8'h00, 0, "sim_idle"};
        vecs[17] = '{8'h00, 8'h00, 0, 3'd3, 8'h00, 0, "sim_stay_idle"};

        do_reset();
        chk_out("reset", 0, 3'd0, 8'h00, 0, 0);

        foreach (vecs[i]) begin
            req_i  = vecs[i].req;
            done_i = vecs[i].done;
            tick();
            chk_out(vecs[i].name, vecs[i].en, vecs[i].sel, vecs[i].grant, vecs[i].busy, 0);
        end
        done_i = '0;

        // Reset while granted: outputs must clear before any clock edge.
        req_i = 8'h08;
        tick();
        chk_out("t5_pre", 1, 3'd3, 8'h08, 1, 0);
        reset_i = 1'b1;
        #1;
        chk_out("t5_async", 0, 3'd0, 8'h00, 0, 0);
        tick();
        reset_i = 1'b0;
        req_i   = 8'h80;
        tick();
        chk_out("t5_after", 1, 3'd7, 8'h80, 1, 0);

        // Full rotation with every requester active.
        do_reset();
        req_i = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            automatic logic [2:0] w = 3'(k % 8);
            tick();
            chk_out($sformatf("t2_grant%0d", k), 1, w, 8'h01 << w, 1, 0);
            done_i = 8'h01 << w;
            tick();
            chk_out($sformatf("t2_gap%0d", k), 0, w, 8'h00, 1, 0);
            done_i = '0;
            tick();
            chk_out($sformatf("t2_idle%0d", k), 0, w, 8'h00, 0, 0);
        end
        req_i = '0;
        tick();
        tick();

        // Owner that never releases.
        do_reset();
        req_i = 8'h01;
        tick();
        chk_out("t6_grant", 1, 3'd0, 8'h01, 1, 0);
`ifdef DEC_ARB_TIMEOUT_EN
        en_cnt = 1;
        for (int c = 0; c < 20 && dec_en_o; c++) begin
            tick();
            if (dec_en_o) en_cnt++;
        end
        chk("t6_en_cycles", 32'(en_cnt), 32'd4);
        chk("t6_tmo_pulse", 32'(timeout_o), 32'd1);
        chk("t6_tmo_busy", 32'(busy_o), 32'd1);
        chk("t6_tmo_en", 32'(dec_en_o), 32'd0);
        tick();
        chk("t6_tmo_clear", 32'(timeout_o), 32'd0);
        chk("t6_tmo_idle", 32'(busy_o), 32'd0);
`else
        hold_ok = 1'b1;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (dec_en_o !== 1'b1 || grant_o !== 8'h01 || timeout_o !== 1'b0) hold_ok = 1'b0;
        end
        chk("t6_hold100", 32'(hold_ok), 32'd1);
        req_i = '0;
        tick();
        chk_out("t6_release", 0, 3'd0, 8'h00, 1, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decoder_rr_arbiter.md
Name: decoder_rr_arbiter

Overview:
Round-robin arbiter/sequencer that shares one n-to-2^n enable decoder among 2^n requesters. Selects one requester, drives the decoder's enable and select inputs, holds the grant until the owner signals done, then inserts one dead cycle before re-arbitrating. Sits directly in front of the decoder so only one decoder output is ever active at a time.

Parameters:
n, 3, decoder select width; the number of requesters is 2^n.
HOLD_MAX, 16, maximum number of cycles an owner may hold the grant. Used only when the optional feature is compiled in; must be >= 1.

Ports:
clk  input  1  clock, rising-edge active
reset  input  1  asynchronous, active-high reset
req  input  2^n  request vector, bit i = requester i
done  input  2^n  release strobe, bit i = requester i finished
dec_en  output  1  decoder enable
dec_sel  output  n  decoder select (index of the granted requester)
grant  output  2^n  one-hot grant; equals the decoder output pattern whenever dec_en=1
busy  output  1  high in GRANT and GAP states
timeout  output  1  one-cycle pulse when a grant is revoked by the watchdog (tied 0 when the feature is out)

Behaviour:
- One clock domain. All outputs are registered.
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, dec_en=0, dec_sel=0, grant=0, busy=0, timeout=0.
  - Round-robin pointer ptr = 2^n-1, so requester 0 has first priority.
- States: IDLE, GRANT, GAP.
- IDLE:
  - If req!=0, pick the first set bit scanning ptr+1, ptr+2, ... modulo 2^n.
  - On the next edge: dec_sel=winner, grant=1<<winner, dec_en=1, busy=1, ptr=winner, go to GRANT.
  - Latency: req asserted at edge k gives a grant visible after edge k+1.
- GRANT:
  - Hold dec_sel, grant and dec_en stable.
  - Release condition: done[dec_sel]=1 or req[dec_sel]=0. On release, the next edge clears dec_en and grant and goes to GAP.
  - done bits of non-owners are ignored.
- GAP:
  - One cycle with dec_en=0 and busy=1.
  - Then go to IDLE. No arbitration happens in GAP.
  - Minimum spacing between two grants is therefore 2 idle-enable cycles.
- Fairness: a requester that keeps req high cannot win twice in a row while another request is pending, because the scan always starts after ptr.
- Wrap-around: with ptr=2^n-1, the scan starts at index 0.
- Simultaneous events:
  - Arbitration uses the req value sampled in IDLE only.
  - A request arriving during GRANT or GAP waits.
  - done and a req drop in the same cycle count as a single release.
- Reset mid-grant: dec_en and grant clear immediately and ptr returns to 2^n-1.
- Invariants: popcount(grant)<=1; grant!=0 exactly when dec_en=1; grant==(1<<dec_sel) whenever dec_en=1.

Optional Feature:
- Macro: DEC_ARB_TIMEOUT_EN.
- Defined:
  - A hold counter clears on entry to GRANT and increments every GRANT cycle.
  - If it reaches HOLD_MAX-1 without a release, the next edge forces a transition to GAP and pulses timeout=1 for exactly that cycle.
  - ptr still equals the revoked index, so the revoked requester gets lowest priority next round.
- Not defined: no counter is built, timeout is tied to 0, and a grant lasts until release.

Test Plan:
1. Reset with req=0 -> dec_en=0, grant=0, busy=0, dec_sel=0. Then req=8'b0000_0001 -> after one edge, dec_sel=0, grant=8'h01, dec_en=1.
2. n=3, req=8'hFF held, done pulsed each grant -> grant order 0,1,2,...,7,0. Each grant is separated by a GAP cycle with dec_en=0.
3. Owner 5, then req=8'h24 (bits 2 and 5) -> next winner is 2, not 5 (wrap-around fairness).
4. During GRANT to 3, pulse done[6] -> no change. Then drop req[3] -> GAP on the next edge, then IDLE.
5. Assert reset while dec_en=1 -> dec_en and grant go to 0 without a clock edge. After release, req=8'h80 wins (ptr reset).
6. With DEC_ARB_TIMEOUT_EN, HOLD_MAX=4, owner never releases -> dec_en high exactly 4 cycles, then timeout=1 for 1 cycle. Without the macro, the grant holds for 100 cycles and timeout stays 0.
